// File: rtl/bf_pkg.sv
// Shared op-code values and FSM state encoding for the BrainFuzz data-tape engine.
package bf_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_PTR_INC  = 3'd1;
    localparam logic [2:0] OP_PTR_DEC  = 3'd2;
    localparam logic [2:0] OP_CELL_INC = 3'd3;
    localparam logic [2:0] OP_CELL_DEC = 3'd4;
    localparam logic [2:0] OP_CELL_WR  = 3'd5;
    localparam logic [2:0] OP_CELL_RD  = 3'd6;
    localparam logic [2:0] OP_TAPE_CLR = 3'd7;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_WRITE = 3'd4
    } tape_state_e;

endpackage

// File: rtl/bf_tape_ram.sv
// Single-port synchronous tape memory: one write or one registered read per cycle.
module bf_tape_ram #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port plus one-cycle registered read of the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/bf_tape_unit.sv
// BrainFuzz data-tape engine: pointer, cached current cell and a clear sweep,
// driven by a valid/ready op stream.
module bf_tape_unit
    import bf_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  bit WRAP_PTR = 1'b1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [WIDTH-1:0]  op_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [ADDR_W-1:0] ptr,
    output logic              cell_zero,
    output logic              ptr_wrap,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    tape_state_e       state_r, state_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic [ADDR_W-1:0] clr_addr_r, clr_addr_s;
    logic [WIDTH-1:0]  cur_r, cur_s;
    logic [WIDTH-1:0]  rsp_data_r, rsp_data_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              ptr_wrap_r, ptr_wrap_s;
    logic              err_r, err_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [WIDTH-1:0]  ram_wdata_s;
    logic [WIDTH-1:0]  ram_rdata_s;

    bf_tape_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, datapath updates and RAM port steering.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        clr_addr_s  = clr_addr_r;
        cur_s       = cur_r;
        rsp_data_s  = rsp_data_r;
        rsp_valid_s = 1'b0;
        ptr_wrap_s  = 1'b0;
        err_s       = err_r;
        ram_we_s    = 1'b0;
        ram_addr_s  = ptr_r;
        ram_wdata_s = cur_r;
        case (state_r)
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = clr_addr_r;
                ram_wdata_s = '0;
                if (clr_addr_r == LAST_ADDR) begin
                    clr_addr_s = '0;
                    state_s    = ST_IDLE;
                end else begin
                    clr_addr_s = clr_addr_r + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_PTR_INC: begin
                            if (ptr_r == LAST_ADDR) begin
                                if (WRAP_PTR) begin
                                    ptr_s      = '0;
                                    ptr_wrap_s = 1'b1;
                                    state_s    = ST_FETCH;
                                end else begin
                                    err_s = 1'b1;
                                end
                            end else begin
                                ptr_s   = ptr_r + ADDR_W'(1);
                                state_s = ST_FETCH;
                            end
                        end
                        OP_PTR_DEC: begin
                            if (ptr_r == '0) begin
                                if (WRAP_PTR) begin
                                    ptr_s      = LAST_ADDR;
                                    ptr_wrap_s = 1'b1;
                                    state_s    = ST_FETCH;
                                end else begin
                                    err_s = 1'b1;
                                end
                            end else begin
                                ptr_s   = ptr_r - ADDR_W'(1);
                                state_s = ST_FETCH;
                            end
                        end
                        OP_CELL_INC: begin
                            cur_s   = cur_r + WIDTH'(1);
                            state_s = ST_WRITE;
                        end
                        OP_CELL_DEC: begin
                            cur_s   = cur_r - WIDTH'(1);
                            state_s = ST_WRITE;
                        end
                        OP_CELL_WR: begin
                            cur_s   = op_wdata;
                            state_s = ST_WRITE;
                        end
                        OP_CELL_RD: begin
                            rsp_valid_s = 1'b1;
                            rsp_data_s  = cur_r;
                        end
                        OP_TAPE_CLR: begin
                            ptr_s      = '0;
                            cur_s      = '0;
                            err_s      = 1'b0;
                            clr_addr_s = '0;
                            state_s    = ST_CLEAR;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                cur_s   = ram_rdata_s;
                state_s = ST_IDLE;
            end
            ST_WRITE: begin
                ram_we_s = 1'b1;
                state_s  = ST_IDLE;
            end
            default: begin
                clr_addr_s = '0;
                state_s    = ST_CLEAR;
            end
        endcase
    end

    // State and datapath registers; reset restarts the clear sweep.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= ST_CLEAR;
            ptr_r       <= '0;
            clr_addr_r  <= '0;
            cur_r       <= '0;
            rsp_data_r  <= '0;
            rsp_valid_r <= 1'b0;
            ptr_wrap_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            clr_addr_r  <= clr_addr_s;
            cur_r       <= cur_s;
            rsp_data_r  <= rsp_data_s;
            rsp_valid_r <= rsp_valid_s;
            ptr_wrap_r  <= ptr_wrap_s;
            err_r       <= err_s;
        end
    end

    assign op_ready  = (state_r == ST_IDLE);
    assign cell_zero = (cur_r == '0);
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign ptr       = ptr_r;
    assign ptr_wrap  = ptr_wrap_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bf_tape_unit.sv
// Bench for bf_tape_unit: a wrapping 16-cell tape and a bounded 10-cell tape,
// directed scenarios plus random ops checked against an array model of the tape.
module tb_bf_tape_unit;
    import bf_pkg::*;

    logic       clk = 1'b0;
    logic       rstb;
    logic       op_valid;
    logic [2:0] op_code;
    logic [7:0] op_wdata;
    bit         sel;

    logic       a_valid, a_ready, a_rsp_valid, a_cz, a_wrap, a_err;
    logic [7:0] a_rsp_data;
    logic [3:0] a_ptr;
    logic       b_valid, b_ready, b_rsp_valid, b_cz, b_wrap, b_err;
    logic [7:0] b_rsp_data;
    logic [3:0] b_ptr;

    logic       obs_ready, obs_rsp_valid, obs_cz, obs_wrap, obs_err;
    logic [7:0] obs_rsp_data;
    logic [3:0] obs_ptr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_mem [16];
    int         m_ptr;
    bit         m_err;
    logic [7:0] m_last_rsp;
    int         depth;
    bit         wrap;

    always #5 clk = ~clk;

    assign a_valid = op_valid & ~sel;
    assign b_valid = op_valid & sel;

    bf_tape_unit #(.WIDTH(8), .DEPTH(16), .WRAP_PTR(1'b1)) dut_a (
        .clk(clk), .rstb(rstb), .op_valid(a_valid), .op_ready(a_ready),
        .op_code(op_code), .op_wdata(op_wdata), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .ptr(a_ptr), .cell_zero(a_cz),
        .ptr_wrap(a_wrap), .err(a_err)
    );

    bf_tape_unit #(.WIDTH(8), .DEPTH(10), .WRAP_PTR(1'b0)) dut_b (
        .clk(clk), .rstb(rstb), .op_valid(b_valid), .op_ready(b_ready),
        .op_code(op_code), .op_wdata(op_wdata), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .ptr(b_ptr), .cell_zero(b_cz),
        .ptr_wrap(b_wrap), .err(b_err)
    );

    assign obs_ready     = sel ? b_ready     : a_ready;
    assign obs_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign obs_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
    assign obs_ptr       = sel ? b_ptr       : a_ptr;
    assign obs_cz        = sel ? b_cz        : a_cz;
    assign obs_wrap      = sel ? b_wrap      : a_wrap;
    assign obs_err       = sel ? b_err       : a_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic select(input bit s);
        sel   = s;
        depth = s ? 10 : 16;
        wrap  = !s;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr      = 0;
        m_err      = 1'b0;
        m_last_rsp = 8'h00;
    endtask

    // Called at a negedge with rstb low; releases reset and times the clear sweep.
    task automatic release_and_count();
        int n;
        check("rst_ptr", obs_ptr, 0);
        check("rst_ready", obs_ready, 0);
        check("rst_cell_zero", obs_cz, 1);
        check("rst_err", obs_err, 0);
        check("rst_rsp", {obs_rsp_valid, obs_rsp_data}, 0);
        rstb = 1'b1;
        model_reset();
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (obs_ready === 1'b1) break;
        end
        check("clear_cycles", n, depth);
    endtask

    task automatic do_op(input logic [2:0] code, input logic [7:0] wd);
        int         exp_lat;
        int         lat;
        bit         exp_rsp;
        bit         exp_wrap;
        int         n;
        exp_lat  = 1;
        exp_rsp  = 1'b0;
        exp_wrap = 1'b0;
        n = 0;
        while (obs_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", obs_ready, 1);
        op_valid = 1'b1;
        op_code  = code;
        op_wdata = wd;
        case (code)
            OP_PTR_INC: begin
                if (m_ptr == depth - 1) begin
                    if (wrap) begin m_ptr = 0; exp_wrap = 1'b1; exp_lat = 3; end
                    else m_err = 1'b1;
                end else begin
                    m_ptr++; exp_lat = 3;
                end
            end
            OP_PTR_DEC: begin
                if (m_ptr == 0) begin
                    if (wrap) begin m_ptr = depth - 1; exp_wrap = 1'b1; exp_lat = 3; end
                    else m_err = 1'b1;
                end else begin
                    m_ptr--; exp_lat = 3;
                end
            end
            OP_CELL_INC: begin m_mem[m_ptr] = m_mem[m_ptr] + 8'd1; exp_lat = 2; end
            OP_CELL_DEC: begin m_mem[m_ptr] = m_mem[m_ptr] - 8'd1; exp_lat = 2; end
            OP_CELL_WR:  begin m_mem[m_ptr] = wd; exp_lat = 2; end
            OP_CELL_RD:  begin exp_rsp = 1'b1; m_last_rsp = m_mem[m_ptr]; end
            OP_TAPE_CLR: begin
                for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
                m_ptr = 0; m_err = 1'b0; exp_lat = 1 + depth;
            end
            default: begin end
        endcase
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        check("rsp_valid", obs_rsp_valid, exp_rsp);
        check("rsp_data", obs_rsp_data, m_last_rsp);
        check("ptr_wrap", obs_wrap, exp_wrap);
        check("ptr", obs_ptr, m_ptr);
        check("err", obs_err, m_err);
        lat = 1;
        while (obs_ready !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_cycles", lat, exp_lat);
        check("cell_zero", obs_cz, (m_mem[m_ptr] == 8'h00));
        @(negedge clk);
        check("pulse_clear", {obs_rsp_valid, obs_wrap}, 0);
        check("rsp_hold", obs_rsp_data, m_last_rsp);
    endtask

    task automatic random_ops(input int count);
        logic [2:0] c;
        for (int k = 0; k < count; k++) begin
            c = 3'($urandom_range(0, 7));
            if (c == OP_TAPE_CLR && $urandom_range(0, 3) != 0) c = OP_CELL_RD;
            do_op(c, 8'($urandom));
        end
    endtask

    initial begin
        rstb     = 1'b0;
        op_valid = 1'b0;
        op_code  = 3'd0;
        op_wdata = 8'h00;
        select(1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        release_and_count();
        do_op(OP_CELL_RD, 8'h00);

        do_op(OP_CELL_WR, 8'hFF);
        do_op(OP_CELL_INC, 8'h00);
        do_op(OP_CELL_DEC, 8'h00);
        do_op(OP_CELL_RD, 8'h00);

        do_op(OP_CELL_WR, 8'h41);
        do_op(OP_PTR_INC, 8'h00);
        do_op(OP_CELL_WR, 8'h42);
        do_op(OP_PTR_DEC, 8'h00);
        do_op(OP_CELL_RD, 8'h00);
        do_op(OP_PTR_INC, 8'h00);
        do_op(OP_CELL_RD, 8'h00);
        do_op(OP_NOP, 8'h00);

        do_op(OP_PTR_DEC, 8'h00);
        do_op(OP_PTR_DEC, 8'h00);
        do_op(OP_PTR_INC, 8'h00);

        random_ops(300);
        for (int i = 0; i < 16; i++) do_op(OP_CELL_WR, 8'(i + 1));

        // Reset asserted during the FETCH cycle of a pointer move.
        while (obs_ready !== 1'b1) @(negedge clk);
        op_valid = 1'b1;
        op_code  = OP_PTR_INC;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        rstb = 1'b0;
        #1;
        check("midrst_ptr", obs_ptr, 0);
        check("midrst_ready", obs_ready, 0);
        @(negedge clk);
        release_and_count();
        for (int i = 0; i < 16; i++) begin
            do_op(OP_CELL_RD, 8'h00);
            do_op(OP_PTR_INC, 8'h00);
        end

        select(1'b1);
        rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        release_and_count();
        do_op(OP_PTR_DEC, 8'h00);
        do_op(OP_CELL_RD, 8'h00);
        for (int i = 0; i < 10; i++) begin
            do_op(OP_CELL_WR, 8'(8'hA0 + i));
            do_op(OP_PTR_INC, 8'h00);
        end
        do_op(OP_TAPE_CLR, 8'h00);
        for (int i = 0; i < 10; i++) begin
            do_op(OP_CELL_RD, 8'h00);
            do_op(OP_PTR_INC, 8'h00);
        end
        random_ops(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_tape_unit.md
Name: bf_tape_unit

Overview:
- Parametrised data-tape engine for the BrainFuzz interpreter. It replaces the fixed 16x8 RAM chip plus bench-driven CEb/WEb/OEb strobes with a clocked block.
- Owns a DEPTH x WIDTH cell memory, the data pointer, and a cached current-cell register.
- Executes BrainFuzz tape ops (`> < + - , .` and tape clear) over a valid/ready handshake.
- Drives the cell_zero flag that the instruction sequencer uses for `[` and `]` evaluation.

Parameters:
- WIDTH, 8, cell width in bits; cell arithmetic is modulo 2^WIDTH.
- DEPTH, 16, number of tape cells; need not be a power of two, must be >= 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.
- WRAP_PTR, 1, 1 = pointer wraps at the ends; 0 = pointer holds at the ends and sets err.

Ports:
- clk  in  1  single clock, rising edge
- rstb  in  1  asynchronous, active-low reset
- op_valid  in  1  op request
- op_ready  out  1  block can accept an op this cycle
- op_code  in  3  0 NOP, 1 PTR_INC, 2 PTR_DEC, 3 CELL_INC, 4 CELL_DEC, 5 CELL_WR, 6 CELL_RD, 7 TAPE_CLR
- op_wdata  in  WIDTH  data for CELL_WR
- rsp_valid  out  1  one-cycle pulse, CELL_RD result
- rsp_data  out  WIDTH  CELL_RD result; holds its value between pulses
- ptr  out  ADDR_W  current data pointer
- cell_zero  out  1  current cell == 0
- ptr_wrap  out  1  one-cycle pulse when the pointer wraps
- err  out  1  sticky pointer-bound violation (WRAP_PTR=0 only)

Behaviour:
- Reset is asynchronous on rstb low. It forces: ptr=0, cur_q=0, cell_zero=1, op_ready=0, rsp_valid=0, rsp_data=0, ptr_wrap=0, err=0, state=CLEAR, clear address=0. Memory contents are not reset.
- An op is accepted in cycle T when op_valid & op_ready are both high. op_code and op_wdata are sampled only in cycle T.
- States: CLEAR, IDLE, FETCH, LOAD, WRITE. op_ready is 1 only in IDLE.
- CLEAR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle.
  - After the write to DEPTH-1 the block goes to IDLE.
  - After rstb rises, op_ready first goes high in cycle DEPTH.
- PTR_INC / PTR_DEC:
  - ptr updates at the end of T; state goes IDLE->FETCH (RAM read of the new ptr)->LOAD (cur_q <= read data)->IDLE.
  - op_ready is low in T+1 and T+2, high in T+3. cur_q and cell_zero are valid from T+3.
  - Wrap (WRAP_PTR=1): DEPTH-1 -> 0 on INC, 0 -> DEPTH-1 on DEC. ptr_wrap pulses in T+1.
  - Bound (WRAP_PTR=0): ptr is unchanged, err sets at the end of T, no fetch, op_ready stays high.
- CELL_INC / CELL_DEC / CELL_WR:
  - cur_q <= cur_q+1, cur_q-1, or op_wdata respectively, at the end of T. Arithmetic is modulo 2^WIDTH.
  - State goes to WRITE, which writes cur_q to mem[ptr] in T+1.
  - cell_zero reflects the new value from T+1. op_ready is low in T+1, high in T+2.
  - Boundaries: INC of 2^WIDTH-1 gives 0; DEC of 0 gives 2^WIDTH-1.
- CELL_RD: rsp_data <= cur_q and rsp_valid=1 in T+1. No busy cycle; op_ready stays high, so back-to-back reads are allowed.
- NOP: accepted, no effect.
- TAPE_CLR:
  - ptr <= 0, cur_q <= 0, err <= 0, state goes to CLEAR.
  - Busy for DEPTH cycles; op_ready is high again in T+1+DEPTH.
- cell_zero is always (cur_q == 0), taken combinationally from the register.
- Reset mid-op (any state): everything aborts, all reset values apply, and the clear sweep restarts.
- The memory is a synchronous array with 1-cycle registered read and single-cycle write. Only one port is used per cycle, so there are no read/write collisions.

Decomposition:
- Package bf_pkg holds:
  - the op_code localparams (OP_NOP..OP_TAPE_CLR, 3 bits);
  - the state encoding (ST_CLEAR, ST_IDLE, ST_FETCH, ST_LOAD, ST_WRITE).
- Sub-module bf_tape_ram: parametrised WIDTH/DEPTH synchronous RAM with ports clk, we, addr, wdata, rdata (1-cycle read latency), no reset.
- bf_tape_unit contains the FSM, the pointer, cur_q, and the flags.

Test Plan:
- Reset then hold: release rstb and count cycles -> op_ready rises exactly 16 cycles after release; ptr=0, cell_zero=1; CELL_RD gives rsp_data=0x00.
- Cell arithmetic: CELL_WR 0xFF, then CELL_INC -> cur 0x00, cell_zero=1. Then CELL_DEC -> 0xFF, cell_zero=0. A following CELL_RD pulses rsp_valid once with 0xFF.
- Pointer and persistence: write 0x41 at cell 0, PTR_INC, write 0x42, PTR_DEC -> CELL_RD returns 0x41 with op_ready low for exactly 2 cycles after each PTR op. PTR_INC then CELL_RD -> 0x42.
- Wrap (DEPTH=16, WRAP_PTR=1): PTR_DEC at ptr=0 -> ptr=15, ptr_wrap pulses once. PTR_INC at 15 -> ptr=0, ptr_wrap pulses again.
- Bound (WRAP_PTR=0, DEPTH=10): PTR_DEC at ptr=0 -> ptr stays 0, err=1 and stays set. TAPE_CLR -> err=0, all 10 cells read back 0x00, op_ready high again 11 cycles after the accept cycle.
- Mid-op reset: assert rstb low in the FETCH cycle of a PTR_INC -> ptr=0 and op_ready=0 immediately. After release the clear sweep reruns and every cell reads 0.
